// File: rtl/interp_pkg.sv
// interp_pkg: shared defaults and FSM state encoding for the interpolation row fetcher
package interp_pkg;
  localparam int NUM_ROWS_DEF = 15;
  localparam int ROW_W_DEF = 120;
  localparam int ADDR_W_DEF = 8;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, FIN} state_e;
endpackage

// File: rtl/row_skid_fifo.sv
// row_skid_fifo: 2-entry FIFO whose head is held stable until popped
module row_skid_fifo
  import interp_pkg::*;
#(
  parameter int W = ROW_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);
  logic [W-1:0] d0_q, d0_d, d1_q, d1_d;
  logic [1:0] cnt_q, cnt_d;
  logic pop, push_ok;
  assign valid = cnt_q != 2'd0;
  assign rdata = valid ? d0_q : '0;
  assign count = cnt_q;
  assign pop = valid && ready;
  assign push_ok = push && (cnt_q != 2'd2 || pop);
  // entry 0 is always the head; entry 1 shifts down on pop
  always_comb begin
    d0_d = (pop && cnt_q == 2'd2) ? d1_q
         : (push_ok && (cnt_q == 2'd0 || (pop && cnt_q == 2'd1))) ? wdata : d0_q;
    d1_d = (push_ok && ((cnt_q == 2'd2) || (cnt_q == 2'd1 && !pop))) ? wdata : d1_q;
    cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      d0_q <= '0;
      d1_q <= '0;
      cnt_q <= 2'd0;
    end else begin
      d0_q <= d0_d;
      d1_q <= d1_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/interp_row_fetch_ctrl.sv
// interp_row_fetch_ctrl: fetches one block of reference rows and streams them to the interpolation datapath
module interp_row_fetch_ctrl
  import interp_pkg::*;
#(
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int ROW_W = ROW_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_row,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [ROW_W-1:0]  mem_data,
  output logic              dp_valid,
  output logic [ROW_W-1:0]  dp_row,
  input  logic              dp_ready,
  output logic              busy,
  output logic              done,
  output logic [3:0]        row_cnt,
  output logic              protocol_err
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0] idx_q, idx_d, row_cnt_q, row_cnt_d;
  logic perr_q, perr_d;
  logic [1:0] occ;
  logic push, pop;
  assign push = state_q == WAIT && mem_valid;
  assign pop = dp_valid && dp_ready;
  row_skid_fifo #(.W(ROW_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (mem_data),
    .ready (dp_ready),
    .valid (dp_valid),
    .rdata (dp_row),
    .count (occ)
  );
  assign busy = state_q == ISSUE || state_q == WAIT || state_q == DRAIN;
  assign done = state_q == FIN;
  assign mem_addr = mem_req ? base_q + ADDR_W'(idx_q) : '0;
  assign row_cnt = row_cnt_q;
  assign protocol_err = perr_q;
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    idx_d = idx_q;
    row_cnt_d = (pop && row_cnt_q != 4'(NUM_ROWS)) ? row_cnt_q + 4'd1 : row_cnt_q;
    perr_d = perr_q || (mem_valid && state_q != WAIT);
    mem_req = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = ISSUE;
        base_d = base_row;
        idx_d = 4'd0;
        row_cnt_d = 4'd0;
        perr_d = mem_valid;
      end
      // a free slot is needed before issuing so the returning row always fits
      ISSUE: if (occ < 2'd2) begin
        mem_req = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (mem_valid) begin
        idx_d = idx_q + 4'd1;
        state_d = (idx_q == 4'(NUM_ROWS - 1)) ? DRAIN : ISSUE;
      end
      DRAIN: state_d = dp_valid ? DRAIN : FIN;
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q <= '0;
      idx_q <= 4'd0;
      row_cnt_q <= 4'd0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      idx_q <= idx_d;
      row_cnt_q <= row_cnt_d;
      perr_q <= perr_d;
    end
  end
endmodule

// File: tb/tb_interp_row_fetch_ctrl.sv
// tb_interp_row_fetch_ctrl: table-driven block fetches with a row scoreboard plus reset/protocol sequences
module tb_interp_row_fetch_ctrl;
  localparam int ROW_W = 120;
  localparam int ADDR_W = 8;
  logic clk, rst, start, mem_req, mem_valid, dp_valid, dp_ready, busy, done, protocol_err;
  logic [ADDR_W-1:0] base_row, mem_addr;
  logic [ROW_W-1:0] mem_data, dp_row;
  logic [3:0] row_cnt;

  interp_row_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_row     (base_row),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_valid    (mem_valid),
    .mem_data     (mem_data),
    .dp_valid     (dp_valid),
    .dp_row       (dp_row),
    .dp_ready     (dp_ready),
    .busy         (busy),
    .done         (done),
    .row_cnt      (row_cnt),
    .protocol_err (protocol_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] base;
    int stall_at;
    int stall_len;
    int done_cyc;
    int exp_cnt;
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  logic [ROW_W-1:0] sb[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic pv = 1'b0, mv_prev = 1'b0, req_prev = 1'b0, resp_en = 1'b1, lat_chk = 1'b0;
  logic [ROW_W-1:0] prev_row = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Advance one cycle; inputs set by the caller afterwards apply to the new cycle.
  task automatic cycle();
    logic [127:0] r;
    @(posedge clk);
    #1;
    if (pv && dp_ready) begin
      chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) chk("dp_row", 128'(prev_row), 128'(sb.pop_front()));
    end else if (pv) begin
      chk("hold_valid", 128'(dp_valid), 128'(1));
      chk("hold_row", 128'(dp_row), 128'(prev_row));
    end
    if (lat_chk && mv_prev) chk("dp_latency", 128'(dp_valid), 128'(1));
    pv = dp_valid;
    prev_row = dp_row;
    mem_valid = req_prev && resp_en;
    if (mem_valid) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      mem_data = r[ROW_W-1:0];
      sb.push_back(mem_data);
    end
    mv_prev = mem_valid;
    if (mem_req) begin
      chk("req_expected", 128'(exp_addr.size() != 0), 128'(1));
      if (exp_addr.size() != 0) chk("mem_addr", 128'(mem_addr), 128'(exp_addr.pop_front()));
    end
    req_prev = mem_req;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_req"}, 128'(mem_req), 128'(0));
    chk({tag, "_mem_addr"}, 128'(mem_addr), 128'(0));
    chk({tag, "_dp_valid"}, 128'(dp_valid), 128'(0));
    chk({tag, "_dp_row"}, 128'(dp_row), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_row_cnt"}, 128'(row_cnt), 128'(0));
    chk({tag, "_perr"}, 128'(protocol_err), 128'(0));
  endtask

  task automatic run_block(input vec_t v);
    int dones = 0, done_at = 0, stall_reqs = 0;
    for (int k = 0; k < 15; k++) exp_addr.push_back(v.base + 8'(k));
    lat_chk = v.stall_len == 0;
    dp_ready = 1'b1;
    start = 1'b1;
    base_row = v.base;
    for (int cyc = 1; cyc <= 400 && dones == 0; cyc++) begin
      cycle();
      start = 1'b0;
      if (cyc == 1) begin
        chk("req_latency", 128'(mem_req), 128'(1));
        chk("busy_set", 128'(busy), 128'(1));
        chk("perr_cleared", 128'(protocol_err), 128'(0));
        chk("row_cnt_cleared", 128'(row_cnt), 128'(0));
      end
      if (cyc == 5) begin
        start = 1'b1;
        base_row = ~v.base;
      end
      dp_ready = !(v.stall_len > 0 && cyc >= v.stall_at && cyc < v.stall_at + v.stall_len);
      if (v.stall_len > 0 && cyc >= v.stall_at + 6 && cyc < v.stall_at + v.stall_len && mem_req)
        stall_reqs++;
      if (done) begin
        dones++;
        done_at = cyc;
      end
    end
    lat_chk = 1'b0;
    chk("done_seen", 128'(dones), 128'(1));
    if (v.done_cyc != 0) chk("done_cycle", 128'(done_at), 128'(v.done_cyc));
    chk("row_cnt_final", 128'(row_cnt), 128'(v.exp_cnt));
    chk("busy_in_fin", 128'(busy), 128'(0));
    chk("rows_left", 128'(sb.size()), 128'(0));
    chk("addrs_left", 128'(exp_addr.size()), 128'(0));
    if (v.stall_len > 0) chk("stall_reqs", 128'(stall_reqs), 128'(0));
    start = 1'b1;
    base_row = 8'h55;
    cycle();
    start = 1'b0;
    chk("fin_start_busy", 128'(busy), 128'(0));
    chk("fin_start_req", 128'(mem_req), 128'(0));
    chk("done_once", 128'(done), 128'(0));
  endtask

  vec_t vecs[5];

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_row = '0;
    mem_valid = 1'b0;
    mem_data = '0;
    dp_ready = 1'b1;
    vecs[0] = '{8'h10, 0, 0, 33, 15};
    vecs[1] = '{8'hF8, 0, 0, 33, 15};
    vecs[2] = '{8'h40, 8, 10, 0, 15};
    vecs[3] = '{8'h00, 3, 10, 0, 15};
    vecs[4] = '{8'hFF, 20, 10, 0, 15};
    repeat (3) cycle();
    check_zero("reset");
    start = 1'b1;
    base_row = 8'h22;
    mem_valid = 1'b1;
    cycle();
    rst = 1'b0;
    start = 1'b0;
    chk("rst_prio_busy", 128'(busy), 128'(0));
    chk("rst_prio_perr", 128'(protocol_err), 128'(0));
    cycle();
    chk("rst_prio_req", 128'(mem_req), 128'(0));
    chk("rst_prio_busy2", 128'(busy), 128'(0));

    for (int i = 0; i < 5; i++) run_block(vecs[i]);

    mem_valid = 1'b1;
    mem_data = '1;
    cycle();
    chk("stray_perr", 128'(protocol_err), 128'(1));
    chk("stray_dp_valid", 128'(dp_valid), 128'(0));
    chk("stray_busy", 128'(busy), 128'(0));
    cycle();
    chk("stray_perr_sticky", 128'(protocol_err), 128'(1));
    chk("stray_dp_valid2", 128'(dp_valid), 128'(0));
    run_block('{8'h80, 0, 0, 33, 15});

    for (int k = 0; k < 15; k++) exp_addr.push_back(8'h30 + 8'(k));
    start = 1'b1;
    base_row = 8'h30;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 100 && !(row_cnt >= 4'd7 && mem_req); i++) cycle();
    chk("mid_block_reached", 128'(row_cnt >= 4'd7 && mem_req), 128'(1));
    resp_en = 1'b0;
    rst = 1'b1;
    cycle();
    check_zero("mid_rst");
    rst = 1'b0;
    mem_valid = 1'b1;
    mem_data = '1;
    cycle();
    chk("stale_perr", 128'(protocol_err), 128'(1));
    chk("stale_busy", 128'(busy), 128'(0));
    chk("stale_dp_valid", 128'(dp_valid), 128'(0));
    chk("stale_mem_req", 128'(mem_req), 128'(0));
    chk("stale_row_cnt", 128'(row_cnt), 128'(0));
    sb.delete();
    exp_addr.delete();
    resp_en = 1'b1;
    run_block('{8'h30, 0, 0, 33, 15});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
